// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record layout, record kind and capture FSM states.
// COMMIT_TRACE_TIMESTAMP_EN adds a 32-bit capture-cycle timestamp to every record.
package trace_pkg;

  localparam int unsigned VLEN = 64;

  typedef logic [1:0] priv_lvl_t;

  typedef enum logic {
    COMMIT = 1'b0,
    EXC    = 1'b1
  } trace_kind_e;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } trace_state_e;

  typedef struct packed {
    trace_kind_e       kind;
    logic              ovf;
    logic [VLEN-1:0]   pc;
    logic [31:0]       instr;
    logic              we;
    logic              fpr;
    logic [4:0]        rd;
    logic [63:0]       wdata;
    priv_lvl_t         priv;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo_mw.sv
// Multi-write / single-read record FIFO. Lanes 0..wr_cnt_i-1 are written in one cycle;
// the caller guarantees wr_cnt_i never exceeds the free space.
module trace_fifo_mw
  import trace_pkg::*;
#(
  parameter int unsigned LANES = 3,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [$clog2(DEPTH):0] wr_cnt_i,
  input  trace_rec_t             wr_data_i [LANES],
  input  logic                   rd_pop_i,
  output trace_rec_t             rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign pop     = rd_pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt_i);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + wr_cnt_i - CNT_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity lives in count_q and the read mux below.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (CNT_W'(i) < wr_cnt_i) mem[wr_ptr_q + PTR_W'(i)] <= wr_data_i[i];
    end
  end

  // An empty FIFO presents an all-zero head so stale storage never leaks out.
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-stage trace capture: packs retired instructions and exceptions into records and streams them out.
// Optional COMMIT_TRACE_TIMESTAMP_EN stamps every record with a free-running 32-bit cycle counter.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter bit          FILTER_DEBUG    = 1'b1,
  parameter int unsigned DROP_CNT_W      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            trace_en_i,
  input  logic                            flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS*32-1:0]   commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]      we_i,
  input  logic [NR_COMMIT_PORTS-1:0]      fpr_i,
  input  logic [NR_COMMIT_PORTS*5-1:0]    waddr_i,
  input  logic [NR_COMMIT_PORTS*64-1:0]   wdata_i,
  input  logic [1:0]                      priv_lvl_i,
  input  logic                            debug_mode_i,
  input  logic                            ex_valid_i,
  input  logic [63:0]                     ex_cause_i,
  output logic                            rec_valid_o,
  input  logic                            rec_ready_i,
  output logic [$bits(trace_rec_t)-1:0]   rec_o,
  output logic                            busy_o,
  output logic                            overflow_o,
  output logic [DROP_CNT_W-1:0]           drop_cnt_o
);

  localparam int unsigned LANES = NR_COMMIT_PORTS + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  trace_state_e          state_q, state_d;
  trace_rec_t            lanes [LANES];
  trace_rec_t            src;
  trace_rec_t            head;
  logic [CNT_W-1:0]      rec_cnt, k, free, wr_cnt, fifo_count;
  logic                  fifo_empty, capture, accept, drop;
  logic                  pending_ovf_q, overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W:0]   drop_sum;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= OFF;
    else         state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     if (trace_en_i) state_d = RUN;
      RUN:     if (!trace_en_i) state_d = DRAIN;
      DRAIN:   if (fifo_empty || flush_i) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // Sources are visited from last (EXC) to first (port 0); each valid one shifts into lane 0,
  // leaving the valid records packed in ascending port order with EXC last.
  // NOTE: blocking assignments here are intentional; later statements must see earlier updates.
  always_comb begin
    for (int j = 0; j < int'(LANES); j++) lanes[j] = '0;
    rec_cnt = '0;
    src     = '0;
    if (ex_valid_i) begin
      src       = '0;
      src.kind  = EXC;
      src.pc    = commit_pc_i[VLEN-1:0];
      src.wdata = ex_cause_i;
      src.priv  = priv_lvl_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      src.ts    = ts_q;
`endif
      for (int j = int'(LANES) - 1; j > 0; j--) lanes[j] = lanes[j-1];
      lanes[0] = src;
      rec_cnt  = rec_cnt + CNT_W'(1);
    end
    for (int i = int'(NR_COMMIT_PORTS) - 1; i >= 0; i--) begin
      if (commit_ack_i[i]) begin
        src       = '0;
        src.kind  = COMMIT;
        src.pc    = commit_pc_i[i*VLEN +: VLEN];
        src.instr = commit_instr_i[i*32 +: 32];
        src.we    = we_i[i];
        src.fpr   = fpr_i[i];
        src.rd    = waddr_i[i*5 +: 5];
        src.wdata = wdata_i[i*64 +: 64];
        src.priv  = priv_lvl_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        src.ts    = ts_q;
`endif
        for (int j = int'(LANES) - 1; j > 0; j--) lanes[j] = lanes[j-1];
        lanes[0] = src;
        rec_cnt  = rec_cnt + CNT_W'(1);
      end
    end
    lanes[0].ovf = pending_ovf_q;
  end

  // A cycle's records are written all together or not at all; a same-cycle pop is not credited.
  assign capture  = (state_q == RUN) && !flush_i && !(FILTER_DEBUG && debug_mode_i);
  assign k        = capture ? rec_cnt : '0;
  assign free     = CNT_W'(DEPTH) - fifo_count;
  assign accept   = (k != '0) && (k <= free);
  assign drop     = (k != '0) && (k > free);
  assign wr_cnt   = accept ? k : '0;
  assign drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(k);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_ovf_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else if (flush_i) begin
      pending_ovf_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (drop) begin
      pending_ovf_q <= 1'b1;
      overflow_q    <= 1'b1;
      drop_cnt_q    <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end else if (accept) begin
      pending_ovf_q <= 1'b0;
    end
  end

  trace_fifo_mw #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .wr_cnt_i  (wr_cnt),
    .wr_data_i (lanes),
    .rd_pop_i  (rec_ready_i),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign rec_valid_o = !fifo_empty;
  assign rec_o       = head;
  assign busy_o      = (state_q != OFF) || !fifo_empty;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: expected records are queued as stimulus is driven
// and compared in order as the sink accepts them.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 16;

  logic                    clk, rst_n;
  logic                    trace_en, flush, debug_mode, ex_valid, rec_ready;
  logic [NR-1:0]           commit_ack, we, fpr;
  logic [NR*VLEN-1:0]      commit_pc;
  logic [NR*32-1:0]        commit_instr;
  logic [NR*5-1:0]         waddr;
  logic [NR*64-1:0]        wdata;
  logic [1:0]              priv;
  logic [63:0]             ex_cause;
  logic                    rec_valid, busy, overflow;
  logic [$bits(trace_rec_t)-1:0] rec_o;
  logic [DW-1:0]           drop_cnt;
  trace_rec_t              rec_s, mon_exp;

  int tests_run    = 0;
  int tests_failed = 0;
  trace_rec_t exp_q[$];
  logic [31:0] tb_cyc;

  assign rec_s = rec_o;

  commit_trace_buffer #(
    .NR_COMMIT_PORTS (NR),
    .DEPTH           (DEPTH),
    .FILTER_DEBUG    (1'b1),
    .DROP_CNT_W      (DW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trace_en_i     (trace_en),
    .flush_i        (flush),
    .commit_ack_i   (commit_ack),
    .commit_pc_i    (commit_pc),
    .commit_instr_i (commit_instr),
    .we_i           (we),
    .fpr_i          (fpr),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .priv_lvl_i     (priv),
    .debug_mode_i   (debug_mode),
    .ex_valid_i     (ex_valid),
    .ex_cause_i     (ex_cause),
    .rec_valid_o    (rec_valid),
    .rec_ready_i    (rec_ready),
    .rec_o          (rec_o),
    .busy_o         (busy),
    .overflow_o     (overflow),
    .drop_cnt_o     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: value during a cycle equals the timestamp a capture in that cycle carries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  function automatic trace_rec_t mk_commit(input logic [63:0] pc, input logic [31:0] instr,
                                           input logic w, input logic f, input logic [4:0] rd,
                                           input logic [63:0] wd, input logic [1:0] pl, input logic ovf);
    trace_rec_t r;
    r       = '0;
    r.kind  = COMMIT;
    r.ovf   = ovf;
    r.pc    = pc;
    r.instr = instr;
    r.we    = w;
    r.fpr   = f;
    r.rd    = rd;
    r.wdata = wd;
    r.priv  = pl;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    r.ts    = tb_cyc;
`endif
    return r;
  endfunction

  function automatic trace_rec_t mk_exc(input logic [63:0] pc, input logic [63:0] cause,
                                        input logic [1:0] pl, input logic ovf);
    trace_rec_t r;
    r       = '0;
    r.kind  = EXC;
    r.ovf   = ovf;
    r.pc    = pc;
    r.wdata = cause;
    r.priv  = pl;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    r.ts    = tb_cyc;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives both ports from a base pc; acked ports are queued in ascending order when push is set.
  task automatic drive_pair(input logic [1:0] ack, input logic [63:0] base, input bit push, input bit ovf_first);
    logic [63:0] pc;
    bit first;
    first = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      pc = base + 64'(4 * i);
      commit_pc[i*64 +: 64]    = pc;
      commit_instr[i*32 +: 32] = pc[31:0] ^ 32'h0000_0513;
      we[i]                    = (i == 0);
      fpr[i]                   = (i == 1);
      waddr[i*5 +: 5]          = pc[6:2];
      wdata[i*64 +: 64]        = ~pc;
      if (ack[i] && push) begin
        exp_q.push_back(mk_commit(pc, pc[31:0] ^ 32'h0000_0513, (i == 0), (i == 1), pc[6:2], ~pc, priv,
                                  ovf_first && first));
        first = 1'b0;
      end
    end
    commit_ack = ack;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d records still expected", exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (rec_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_valid: rec_valid=%b want 0", rec_valid);
    end
  endtask

  // Scoreboard: every accepted record must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_record: got pc=%h kind=%0d, none expected", rec_s.pc, rec_s.kind);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rec_s !== mon_exp) begin
          tests_failed++;
          $display("FAIL record: got %h want %h", rec_s, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
    tests_run++;
    if (rec_o !== '0) begin tests_failed++; $display("FAIL reset_rec: got %h want 0", rec_o); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++;
    if (drop_cnt !== '0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_port_order();
    trace_en  = 1'b1;
    rec_ready = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL run_busy: got %b want 1", busy); end
    drive_pair(2'b11, 64'h8000_0000, 1'b1, 1'b0);
    tick();
    commit_ack = '0;
    tests_run++;
    if (rec_valid !== 1'b1) begin tests_failed++; $display("FAIL order_cycle1: rec_valid=%b want 1", rec_valid); end
    tick();
    tests_run++;
    if (rec_valid !== 1'b1) begin tests_failed++; $display("FAIL order_cycle2: rec_valid=%b want 1", rec_valid); end
    tick();
    tests_run++;
    if (rec_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL order_done: rec_valid=%b pending=%0d want 0/0", rec_valid, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    rec_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_pair(2'b11, 64'h8000_1000 + 64'(c * 8), 1'b1, 1'b0);
      tick();
    end
    drive_pair(2'b11, 64'h8000_2000, 1'b0, 1'b0);
    tick();
    commit_ack = '0;
    tests_run++;
    if (drop_cnt !== 16'd2) begin tests_failed++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    tests_run++;
    if (rec_s !== exp_q[0]) begin tests_failed++; $display("FAIL ovf_head: got %h want %h", rec_s, exp_q[0]); end
    tick();
    tests_run++;
    if (rec_s !== exp_q[0]) begin tests_failed++; $display("FAIL head_stable: got %h want %h", rec_s, exp_q[0]); end
    rec_ready = 1'b1;
    tick();
    drive_pair(2'b01, 64'h8000_3000, 1'b1, 1'b1);
    tick();
    drive_pair(2'b01, 64'h8000_3100, 1'b1, 1'b0);
    tick();
    commit_ack = '0;
    wait_drain(40);
    tests_run++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL ovf_sticky: overflow=%b drop_cnt=%0d want 1/2", overflow, drop_cnt);
    end
  endtask

  task automatic test_exception();
    rec_ready = 1'b1;
    priv      = 2'b00;
    drive_pair(2'b01, 64'h8000_4000, 1'b1, 1'b0);
    ex_valid = 1'b1;
    ex_cause = 64'd2;
    exp_q.push_back(mk_exc(64'h8000_4000, 64'd2, 2'b00, 1'b0));
    tick();
    drive_pair(2'b10, 64'h8000_5000, 1'b1, 1'b0);
    ex_cause = 64'h0000_0000_0000_000b;
    exp_q.push_back(mk_exc(64'h8000_5000, 64'h0000_0000_0000_000b, 2'b00, 1'b0));
    tick();
    ex_valid   = 1'b0;
    commit_ack = '0;
    priv       = 2'b11;
    wait_drain(20);
  endtask

  task automatic test_flush();
    rec_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_pair(2'b11, 64'h8000_6000 + 64'(c * 8), 1'b0, 1'b0);
      tick();
    end
    drive_pair(2'b11, 64'h8000_6800, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    drive_pair(2'b11, 64'h8000_6900, 1'b0, 1'b0);
    tick();
    flush      = 1'b0;
    commit_ack = '0;
    tests_run++;
    if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b want 0", rec_valid); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_overflow: got %b want 0", overflow); end
    tests_run++;
    if (drop_cnt !== 16'd4) begin tests_failed++; $display("FAIL flush_drop_cnt: got %0d want 4", drop_cnt); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_busy: got %b want 1", busy); end
    rec_ready = 1'b1;
    drive_pair(2'b01, 64'h8000_7000, 1'b1, 1'b0);
    tick();
    commit_ack = '0;
    wait_drain(20);
  endtask

  task automatic test_drain();
    rec_ready = 1'b0;
    drive_pair(2'b11, 64'h8000_8000, 1'b1, 1'b0);
    tick();
    drive_pair(2'b11, 64'h8000_8100, 1'b1, 1'b0);
    tick();
    drive_pair(2'b01, 64'h8000_8200, 1'b1, 1'b0);
    tick();
    trace_en   = 1'b0;
    commit_ack = '0;
    tick();
    trace_en = 1'b1;
    drive_pair(2'b11, 64'h8000_9000, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL drain_busy: got %b want 1", busy); end
    trace_en  = 1'b0;
    rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        tests_run++;
        if (rec_valid !== 1'b1 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL drain_step%0d: valid=%b busy=%b want 1/1", i, rec_valid, busy);
        end
      end
    end
    tests_run++;
    if (rec_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_last: valid=%b busy=%b want 0/1", rec_valid, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL drain_off: busy=%b want 0", busy); end
    commit_ack = '0;
    tick();
    tests_run++;
    if (exp_q.size() != 0 || rec_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_ignored: pending=%0d valid=%b want 0/0", exp_q.size(), rec_valid);
    end
  endtask

  task automatic test_debug_filter();
    trace_en  = 1'b1;
    rec_ready = 1'b1;
    tick();
    debug_mode = 1'b1;
    drive_pair(2'b11, 64'h8000_a000, 1'b0, 1'b0);
    tick();
    debug_mode = 1'b0;
    commit_ack = '0;
    tick();
    tests_run++;
    if (rec_valid !== 1'b0 || drop_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL debug_filter: valid=%b drop_cnt=%0d want 0/4", rec_valid, drop_cnt);
    end
    drive_pair(2'b11, 64'h8000_b000, 1'b1, 1'b0);
    tick();
    commit_ack = '0;
    wait_drain(20);
  endtask

  task automatic test_async_reset();
    rec_ready = 1'b0;
    drive_pair(2'b11, 64'h8000_c000, 1'b0, 1'b0);
    tick();
    commit_ack = '0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (rec_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_state: valid=%b busy=%b want 0/0", rec_valid, busy);
    end
    tests_run++;
    if (drop_cnt !== '0 || overflow !== 1'b0 || rec_o !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_regs: drop_cnt=%0d overflow=%b rec=%h want 0/0/0", drop_cnt, overflow, rec_o);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    rec_ready = 1'b1;
    drive_pair(2'b01, 64'h8000_d000, 1'b1, 1'b0);
    tick();
    commit_ack = '0;
    wait_drain(20);
  endtask

  initial begin
    rst_n = 1'b1; trace_en = 1'b0; flush = 1'b0; debug_mode = 1'b0; ex_valid = 1'b0;
    rec_ready = 1'b0; commit_ack = '0; we = '0; fpr = '0; commit_pc = '0; commit_instr = '0;
    waddr = '0; wdata = '0; priv = 2'b11; ex_cause = '0;
    test_reset();
    test_port_order();
    test_overflow();
    test_exception();
    test_flush();
    test_drain();
    test_debug_filter();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
